uart_bus_loader: RTL and testbench



---
 rtl/loader_pkg.sv | 33 +++
 rtl/loader_timeout.sv | 36 +++
 rtl/uart_bus_loader.sv | 216 +++++++++++++++++++++
 tb/tb_uart_bus_loader.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the UART-driven bus loader: protocol bytes, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package loader_pkg;

  // Command bytes received from the host
  localparam logic [7:0] CMD_W = 8'h57;  // 'W'
  localparam logic [7:0] CMD_R = 8'h52;  // 'R'

  // Single-byte replies sent back to the host
  localparam logic [7:0] RSP_OK  = 8'h2E;  // '.' write command finished
  localparam logic [7:0] RSP_BAD = 8'h3F;  // '?' unknown command byte
  localparam logic [7:0] RSP_TMO = 8'h21;  // '!' host went silent mid-command

  typedef enum logic [3:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    LEN,
    WDATA,
    WBUS,
    RBUS,
    RWAIT,
    RSEND,
    REPLY
  } state_t;

  // A length byte of zero encodes a full 256-byte transfer.
  function automatic logic [8:0] len_to_cnt(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled, flags when TIMEOUT is reached.
// Latency: o_expired is high from the cycle the count equals TIMEOUT (registered count).
// Backpressure: none; i_clr or a dropped i_en restarts the count from zero.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   i_clr      restart the count (a byte arrived)
//   i_en       count only while the command parser waits for a host byte
//   o_expired  count reached TIMEOUT while enabled
module loader_timeout #(
  parameter int TIMEOUT = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr || !i_en) begin
      r_cnt <= '0;
    end else if (r_cnt != LIMIT) begin
      // saturate so the flag stays up until the FSM reacts
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_expired = i_en && (r_cnt == LIMIT);

endmodule

// File: rtl/uart_bus_loader.sv
// Serial-command bus initiator: host bytes in, memory bus read/write cycles, reply bytes out.
// Latency: bus_req 1 cycle after the triggering byte; read data on tx 2 cycles after AB is driven.
// Backpressure: tx bytes held until tx_ready; bus cycles stall until bus_gnt; extra rx bytes dropped.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   rx_data/rx_valid         received byte strobe from the UART receiver
//   tx_data/tx_valid/tx_ready byte towards the UART transmitter (valid/ready)
//   bus_req/bus_gnt          bus ownership request and arbiter grant
//   AB/DO/DI/WE              memory bus: address, write data, read data, write enable
module uart_bus_loader
  import loader_pkg::*;
#(
  parameter int TIMEOUT = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] AB,
  output logic [7:0]  DO,
  input  logic [7:0]  DI,
  output logic        WE
);

  state_t      r_state;
  state_t      w_state_nxt;

  // command datapath
  logic [15:0] r_addr;
  logic [8:0]  r_cnt;
  logic        r_wr;
  logic [7:0]  r_wbyte;
  logic        r_rd_ph;   // RWAIT spans two cycles: AB on the bus, then DI valid

  // registered outputs and their next values
  logic [15:0] r_ab, w_ab_nxt;
  logic [7:0]  r_do, w_do_nxt;
  logic        r_we, w_we_nxt;
  logic        r_bus_req, w_bus_req_nxt;
  logic        r_tx_vld, w_tx_vld_nxt;
  logic [7:0]  r_tx_dat, w_tx_dat_nxt;

  logic        w_tmo_en;
  logic        w_expired;
  logic        w_tmo;
  logic        w_is_cmd;
  logic        w_tx_hs;
  logic        w_last;

  assign w_tmo_en = (r_state == ADDR_HI) || (r_state == ADDR_LO) ||
                    (r_state == LEN)     || (r_state == WDATA);
  // a byte arriving in the expiry cycle still counts as on time
  assign w_tmo    = w_expired && !rx_valid;
  assign w_is_cmd = (rx_data == CMD_W) || (rx_data == CMD_R);
  assign w_tx_hs  = r_tx_vld && tx_ready;
  assign w_last   = (r_cnt == 9'd1);

  loader_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (rx_valid),
    .i_en      (w_tmo_en),
    .o_expired (w_expired)
  );

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (rx_valid) w_state_nxt = w_is_cmd ? ADDR_HI : REPLY;
      end
      ADDR_HI: begin
        if (rx_valid)   w_state_nxt = ADDR_LO;
        else if (w_tmo) w_state_nxt = REPLY;
      end
      ADDR_LO: begin
        if (rx_valid)   w_state_nxt = LEN;
        else if (w_tmo) w_state_nxt = REPLY;
      end
      LEN: begin
        if (rx_valid)   w_state_nxt = r_wr ? WDATA : RBUS;
        else if (w_tmo) w_state_nxt = REPLY;
      end
      WDATA: begin
        if (rx_valid)   w_state_nxt = WBUS;
        else if (w_tmo) w_state_nxt = REPLY;
      end
      WBUS: begin
        if (bus_gnt) w_state_nxt = w_last ? REPLY : WDATA;
      end
      RBUS: begin
        if (bus_gnt) w_state_nxt = RWAIT;
      end
      RWAIT: begin
        if (r_rd_ph) w_state_nxt = RSEND;
      end
      RSEND: begin
        if (w_tx_hs) w_state_nxt = w_last ? IDLE : RBUS;
      end
      REPLY: begin
        if (w_tx_hs) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------- output logic (next values of registered outputs) ----------------
  always_comb begin
    w_ab_nxt     = r_ab;
    w_do_nxt     = r_do;
    w_we_nxt     = 1'b0;
    w_tx_dat_nxt = r_tx_dat;
    w_tx_vld_nxt = (w_state_nxt == RSEND) || (w_state_nxt == REPLY);
    // Request is held across WDATA gaps of a write in progress and through the
    // final WE cycle, so it falls one cycle after the last bus action.
    w_bus_req_nxt = (w_state_nxt == WBUS) || (w_state_nxt == RBUS) ||
                    (w_state_nxt == RWAIT) || (w_state_nxt == RSEND) ||
                    ((w_state_nxt == WDATA) && r_bus_req) ||
                    ((r_state == WBUS) && (w_state_nxt == REPLY));
    unique case (r_state)
      IDLE: begin
        if (rx_valid && !w_is_cmd) w_tx_dat_nxt = RSP_BAD;
      end
      ADDR_HI, ADDR_LO, LEN, WDATA: begin
        if (w_tmo) w_tx_dat_nxt = RSP_TMO;
      end
      WBUS: begin
        if (bus_gnt) begin
          w_ab_nxt = r_addr;
          w_do_nxt = r_wbyte;
          w_we_nxt = 1'b1;
          if (w_last) w_tx_dat_nxt = RSP_OK;
        end
      end
      RBUS: begin
        if (bus_gnt) w_ab_nxt = r_addr;
      end
      RWAIT: begin
        // taken regardless of bus_gnt: the cycle was already issued
        if (r_rd_ph) w_tx_dat_nxt = DI;
      end
      default: ;
    endcase
  end

  // ---------------- datapath and output registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_cnt     <= '0;
      r_wr      <= 1'b0;
      r_wbyte   <= '0;
      r_rd_ph   <= 1'b0;
      r_ab      <= '0;
      r_do      <= '0;
      r_we      <= 1'b0;
      r_bus_req <= 1'b0;
      r_tx_vld  <= 1'b0;
      r_tx_dat  <= '0;
    end else begin
      r_ab      <= w_ab_nxt;
      r_do      <= w_do_nxt;
      r_we      <= w_we_nxt;
      r_bus_req <= w_bus_req_nxt;
      r_tx_vld  <= w_tx_vld_nxt;
      r_tx_dat  <= w_tx_dat_nxt;
      unique case (r_state)
        IDLE:    if (rx_valid) r_wr <= (rx_data == CMD_W);
        ADDR_HI: if (rx_valid) r_addr[15:8] <= rx_data;
        ADDR_LO: if (rx_valid) r_addr[7:0] <= rx_data;
        LEN:     if (rx_valid) r_cnt <= len_to_cnt(rx_data);
        WDATA:   if (rx_valid) r_wbyte <= rx_data;
        WBUS: begin
          if (bus_gnt) begin
            r_addr <= r_addr + 16'd1;
            r_cnt  <= r_cnt - 9'd1;
          end
        end
        RWAIT:   r_rd_ph <= !r_rd_ph;
        RSEND: begin
          if (w_tx_hs) begin
            r_addr <= r_addr + 16'd1;
            r_cnt  <= r_cnt - 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign AB       = r_ab;
  assign DO       = r_do;
  assign WE       = r_we;
  assign bus_req  = r_bus_req;
  assign tx_valid = r_tx_vld;
  assign tx_data  = r_tx_dat;

endmodule

// File: tb/tb_uart_bus_loader.sv
module tb_uart_bus_loader;

  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        bus_req;
  logic        bus_gnt;
  logic [15:0] AB;
  logic [7:0]  DO;
  logic [7:0]  DI;
  logic        WE;

  uart_bus_loader #(.TIMEOUT(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .bus_req  (bus_req),
    .bus_gnt  (bus_gnt),
    .AB       (AB),
    .DO       (DO),
    .DI       (DI),
    .WE       (WE)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state: expected memory image and expected outputs in order
  logic [7:0]  ref_mem [65536];
  logic [7:0]  bus_mem [65536];   // what the DUT actually wrote; drives DI
  logic [7:0]  exp_tx [$];
  logic [15:0] exp_wr_a [$];
  logic [7:0]  exp_wr_d [$];
  logic [7:0]  rx_log [$];        // every byte the DUT handed to the transmitter
  logic [7:0]  wq [$];            // data for the next write command

  // environment knobs
  logic gnt_always = 1'b1;
  int   gnt_delay  = 0;
  int   ready_mode = 0;           // 0: always ready, 1: random, 2: never
  logic forbid_req = 1'b0;
  int   req_cnt    = 0;
  logic [15:0] ab_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: unexpected value %0h", name, act);
  endtask

  function automatic logic [8:0] last_rx(input int k);
    if (rx_log.size() > k) return {1'b0, rx_log[rx_log.size()-1-k]};
    return 9'h1FF;
  endfunction

  // bus responder, arbiter and transmitter ready
  initial begin
    DI = 8'h00;
    bus_gnt = 1'b0;
    tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      ab_s = AB;
      @(posedge clk);
      #1;
      DI = bus_mem[ab_s];
      if (bus_req) req_cnt++; else req_cnt = 0;
      bus_gnt = gnt_always || (bus_req && (req_cnt > gnt_delay));
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // compare process: every cycle out of reset
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (WE) begin
          check("we_needs_gnt", 32'(bus_gnt), 32'd1);
          if (exp_wr_a.size() == 0) flag("we_unexpected", 32'(AB));
          else begin
            check("we_addr", 32'(AB), 32'(exp_wr_a.pop_front()));
            check("we_data", 32'(DO), 32'(exp_wr_d.pop_front()));
          end
          bus_mem[AB] = DO;
        end
        if (tx_valid && tx_ready) begin
          rx_log.push_back(tx_data);
          if (exp_tx.size() == 0) flag("tx_unexpected", 32'(tx_data));
          else check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
        end
        if (forbid_req) check("no_bus_req", 32'(bus_req), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  // write command: data taken from wq; n in 1..256
  task automatic cmd_write(input logic [15:0] addr, input int n);
    logic [15:0] a;
    logic [7:0]  d;
    a = addr;
    exp_tx.push_back(8'h2E);
    send_byte(8'h57, 1);
    send_byte(addr[15:8], 1);
    send_byte(addr[7:0], 1);
    send_byte(8'(n), 1);
    for (int i = 0; i < n; i++) begin
      d = wq.pop_front();
      ref_mem[a] = d;
      exp_wr_a.push_back(a);
      exp_wr_d.push_back(d);
      send_byte(d, 14);
      a = a + 16'd1;
    end
  endtask

  task automatic cmd_read(input logic [15:0] addr, input logic [7:0] len);
    int n;
    logic [15:0] a;
    n = (len == 8'd0) ? 256 : int'(len);
    a = addr;
    for (int i = 0; i < n; i++) begin
      exp_tx.push_back(ref_mem[a]);
      a = a + 16'd1;
    end
    send_byte(8'h52, 1);
    send_byte(addr[15:8], 1);
    send_byte(addr[7:0], 1);
    send_byte(len, 1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while (k < budget && !(exp_tx.size() == 0 && exp_wr_a.size() == 0 && !bus_req && !tx_valid)) begin
      tick();
      k++;
    end
    check(name, 32'(k < budget), 32'd1);
    if (k >= budget) begin
      exp_tx.delete();
      exp_wr_a.delete();
      exp_wr_d.delete();
    end
    repeat (3) tick();
  endtask

  task automatic pulse_rst(input string name);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({name, "_AB"}, 32'(AB), 32'd0);
    check({name, "_DO"}, 32'(DO), 32'd0);
    check({name, "_WE"}, 32'(WE), 32'd0);
    check({name, "_req"}, 32'(bus_req), 32'd0);
    check({name, "_txv"}, 32'(tx_valid), 32'd0);
    check({name, "_txd"}, 32'(tx_data), 32'd0);
    tick();
    rst = 1'b0;
  endtask

  task automatic fill_random(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
  endtask

  initial begin
    int sz;
    logic [15:0] ra;
    logic [7:0]  d;
    int n;

    rst = 1'b1;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      d = 8'($urandom);
      ref_mem[i] = d;
      bus_mem[i] = d;
    end

    // reset state
    repeat (3) tick();
    pulse_rst("reset");
    repeat (2) tick();

    // write 3 bytes at 0x1200 with grant held high
    wq.delete();
    wq.push_back(8'hAA); wq.push_back(8'hBB); wq.push_back(8'hCC);
    cmd_write(16'h1200, 3);
    wait_done("write3_done", 200);
    check("write3_reply", 32'(last_rx(0)), 32'h2E);
    check("write3_mem1201", 32'(bus_mem[16'h1201]), 32'hBB);
    check("write3_mem1202", 32'(bus_mem[16'h1202]), 32'hCC);

    // read 2 bytes across the address wrap
    bus_mem[16'hFFFF] = 8'h11; ref_mem[16'hFFFF] = 8'h11;
    bus_mem[16'h0000] = 8'h22; ref_mem[16'h0000] = 8'h22;
    cmd_read(16'hFFFF, 8'h02);
    wait_done("wrap_done", 200);
    check("wrap_b0", 32'(last_rx(1)), 32'h11);
    check("wrap_b1", 32'(last_rx(0)), 32'h22);

    // unknown command byte
    forbid_req = 1'b1;
    exp_tx.push_back(8'h3F);
    send_byte(8'h41, 1);
    wait_done("bad_done", 50);
    check("bad_reply", 32'(last_rx(0)), 32'h3F);

    // host goes silent after two bytes
    exp_tx.push_back(8'h21);
    send_byte(8'h57, 1);
    send_byte(8'h00, 0);
    repeat (TMO - 10) tick();
    check("tmo_not_early", 32'(exp_tx.size()), 32'd1);
    wait_done("tmo_done", 100);
    forbid_req = 1'b0;
    check("tmo_reply", 32'(last_rx(0)), 32'h21);
    fill_random(4);
    ra = 16'($urandom);
    cmd_write(ra, 4);
    wait_done("post_tmo_write", 300);
    cmd_read(ra, 8'h04);
    wait_done("post_tmo_read", 300);

    // 256-byte read, delayed grant, random transmitter ready
    gnt_always = 1'b0;
    gnt_delay = 5;
    ready_mode = 1;
    sz = rx_log.size();
    cmd_read(16'h0300, 8'h00);
    wait_done("read256_done", 6000);
    check("read256_count", 32'(rx_log.size() - sz), 32'd256);

    // random write/read-back pairs
    for (int it = 0; it < 6; it++) begin
      gnt_delay = $urandom_range(0, 5);
      ready_mode = $urandom_range(0, 1);
      n = $urandom_range(1, 8);
      ra = 16'($urandom);
      fill_random(n);
      cmd_write(ra, n);
      wait_done("rand_write", 600);
      cmd_read(ra - 16'd1, 8'(n + 2));
      wait_done("rand_read", 600);
    end

    // reset while waiting for the next write data byte
    gnt_always = 1'b1;
    ready_mode = 0;
    d = 8'($urandom);
    send_byte(8'h57, 1);
    send_byte(8'h40, 1);
    send_byte(8'h00, 1);
    send_byte(8'h03, 1);
    ref_mem[16'h4000] = d;
    exp_wr_a.push_back(16'h4000);
    exp_wr_d.push_back(d);
    send_byte(d, 8);
    check("wdata_first_written", 32'(exp_wr_a.size()), 32'd0);
    pulse_rst("rst_wdata");
    repeat (20) tick();
    cmd_read(16'h4000, 8'h01);
    wait_done("after_rst_wdata", 200);

    // reset while a read byte is waiting for the transmitter
    ready_mode = 2;
    tick();
    cmd_read(16'h0300, 8'h04);
    n = 0;
    while (!tx_valid && n < 100) begin
      tick();
      n++;
    end
    check("rsend_reached", 32'(tx_valid), 32'd1);
    pulse_rst("rst_rsend");
    exp_tx.delete();
    ready_mode = 0;
    repeat (20) tick();
    cmd_read(16'h0300, 8'h02);
    wait_done("after_rst_rsend", 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d expected tx bytes left", exp_tx.size());
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
